// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Serialiser states, parity-mode encodings and divisor clamping.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [19:0] MIN_DIV = 20'd2;

  function automatic logic [19:0] clamp_div(
    input logic [19:0] d
  );
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic logic par_enabled(
    input logic [1:0] m
  );
    return (m == PAR_ODD) || (m == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy, full/empty and
// a registered pulse for writes dropped while full.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = i_pop && !w_empty;
  // A full FIFO still takes a write when the same edge frees a slot.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= i_push && !w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case (1'b1)
        (w_push && !w_pop): r_level <= r_level + 1'b1;
        (w_pop && !w_push): r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_level    = r_level;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: TX FIFO feeding a frame serialiser
// with per-frame latched divisor, parity mode and stop-bit count.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          WrEn,
  input  logic [DATA_W-1:0]             WrData,
  input  logic [19:0]                   Divisor,
  input  logic [1:0]                    FrameCheck,
  input  logic                          StopBits,
  output logic                          TX_pin,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          Busy,
  output logic                          Doneflg,
  output logic                          Overflow
);

  localparam int BW = 4;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [19:0]       r_div;
  logic [19:0]       r_baud;
  logic [1:0]        r_par_mode;
  logic              r_stop2;
  logic              r_par_bit;
  logic [BW-1:0]     r_bitcnt;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  logic              w_empty;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_head;
  logic [19:0]       w_div;

  assign w_div     = clamp_div(Divisor);
  assign w_bit_end = (r_baud == '0);
  // In STOP, r_bitcnt counts completed stop bits.
  assign w_frame_end = (r_state == ST_STOP) && w_bit_end &&
                       (!r_stop2 || (r_bitcnt != '0));
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || w_frame_end);

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RSTn),
    .i_push     (WrEn),
    .i_pop      (w_pop),
    .i_data     (WrData),
    .o_data     (w_head),
    .o_full     (Full),
    .o_empty    (w_empty),
    .o_level    (Level),
    .o_overflow (Overflow)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_div      <= MIN_DIV;
      r_baud     <= '0;
      r_par_mode <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_par_bit  <= 1'b0;
      r_bitcnt   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_state    <= ST_START;
        r_shift    <= w_head;
        r_div      <= w_div;
        r_baud     <= w_div - 1'b1;
        r_par_mode <= FrameCheck;
        r_stop2    <= StopBits;
        r_par_bit  <= (FrameCheck == PAR_ODD) ? ~^w_head : ^w_head;
        r_bitcnt   <= '0;
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
        r_done     <= w_frame_end;
      end else if (r_state != ST_IDLE) begin
        if (!w_bit_end) begin
          r_baud <= r_baud - 1'b1;
        end else begin
          r_baud <= r_div - 1'b1;
          unique case (r_state)
            ST_START: begin
              r_state  <= ST_DATA;
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= '0;
            end
            ST_DATA: begin
              if (r_bitcnt == LAST_BIT) begin
                r_bitcnt <= '0;
                if (par_enabled(r_par_mode)) begin
                  r_state <= ST_PARITY;
                  r_tx    <= r_par_bit;
                end else begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
                r_tx     <= r_shift[0];
                r_shift  <= r_shift >> 1;
              end
            end
            ST_PARITY: begin
              r_state  <= ST_STOP;
              r_tx     <= 1'b1;
              r_bitcnt <= '0;
            end
            ST_STOP: begin
              if (w_frame_end) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign TX_pin  = r_tx;
  assign Busy    = r_busy;
  assign Doneflg = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: randomized frames
// compared cycle by cycle against a bit-list reference model.
module tb_uart_tx_buffered;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        WrEn = 1'b0;
  logic [7:0]  WrData = '0;
  logic [19:0] Divisor = 20'd4;
  logic [1:0]  FrameCheck = 2'b00;
  logic        StopBits = 1'b0;
  logic        TX_pin;
  logic        Full;
  logic [2:0]  Level;
  logic        Busy;
  logic        Doneflg;
  logic        Overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;

  typedef struct {
    logic [7:0] d;
    int         div;
    logic [1:0] pm;
    logic       s2;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] wr_q[$];
  int         pre_gap;
  int         mid_at;
  logic [19:0] mid_div;
  bit         chk_sat;
  int         exp_level;
  int         exp_ovf;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .WrEn       (WrEn),
    .WrData     (WrData),
    .Divisor    (Divisor),
    .FrameCheck (FrameCheck),
    .StopBits   (StopBits),
    .TX_pin     (TX_pin),
    .Full       (Full),
    .Level      (Level),
    .Busy       (Busy),
    .Doneflg    (Doneflg),
    .Overflow   (Overflow)
  );

  always begin
    @(posedge CLK);
    #2;
    if (Doneflg) done_cnt++;
    if (Overflow) ovf_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int bit_time(input int div);
    return (div < 2) ? 2 : div;
  endfunction

  // Line levels of one frame, one entry per bit time.
  function automatic int frame_bits(
    input  logic [7:0] d,
    input  logic [1:0] pm,
    input  logic       s2,
    output logic [15:0] b
  );
    int n;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1+i] = d[i];
    n = 1 + DW;
    if (pm == 2'b01 || pm == 2'b10) begin
      b[n] = (($countones(d) % 2) == 1) ^ (pm == 2'b01);
      n++;
    end
    n += s2 ? 2 : 1;
    return n;
  endfunction

  task automatic clear_plan();
    wr_q.delete();
    exp_q.delete();
    pre_gap = 0;
    mid_at = 0;
    mid_div = '0;
    chk_sat = 0;
    exp_level = 0;
    exp_ovf = 0;
  endtask

  task automatic add_frame(input logic [7:0] d, input int div,
                           input logic [1:0] pm, input logic s2);
    frame_t f;
    f.d = d; f.div = div; f.pm = pm; f.s2 = s2;
    wr_q.push_back(d);
    exp_q.push_back(f);
  endtask

  task automatic write_byte(input logic [7:0] d);
    WrEn = 1'b1;
    WrData = d;
    @(negedge CLK);
    WrEn = 1'b0;
  endtask

  task automatic check_frame(input frame_t f);
    logic [15:0] b;
    int n, t;
    bit bad;
    logic g_tx, g_busy, g_done;
    n = frame_bits(f.d, f.pm, f.s2, b);
    t = bit_time(f.div);
    for (int i = 0; i < n; i++) begin
      bad = 0;
      g_tx = 1'b0; g_busy = 1'b0; g_done = 1'b0;
      for (int c = 0; c < t; c++) begin
        if (!bad && (TX_pin !== b[i] || Busy !== 1'b1 ||
            ((i > 0 || c > 0) && Doneflg !== 1'b0))) begin
          bad = 1;
          g_tx = TX_pin; g_busy = Busy; g_done = Doneflg;
        end
        @(negedge CLK);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL frame %h bit %0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                 f.d, i, g_tx, g_busy, g_done, b[i]);
      end
    end
    checks++;
    if (Doneflg !== 1'b1) begin
      errors++;
      $display("FAIL done pulse frame %h: got %b want 1", f.d, Doneflg);
    end
  endtask

  task automatic run_frames();
    int d0, o0;
    d0 = done_cnt;
    o0 = ovf_cnt;
    fork
      begin
        for (int k = 0; k < wr_q.size(); k++) begin
          write_byte(wr_q[k]);
          if (k == 0) repeat (pre_gap) @(negedge CLK);
        end
        if (chk_sat) begin
          checks++;
          if (Level !== 3'(exp_level)) begin
            errors++;
            $display("FAIL sat level: got %0d want %0d", Level, exp_level);
          end
          checks++;
          if (Full !== 1'b1) begin
            errors++;
            $display("FAIL sat full: got %b want 1", Full);
          end
        end
      end
      begin
        @(negedge CLK);
        checks++;
        if (TX_pin !== 1'b1) begin
          errors++;
          $display("FAIL latency: tx=%b one cycle after write, want 1", TX_pin);
        end
        @(negedge CLK);
        for (int k = 0; k < exp_q.size(); k++) check_frame(exp_q[k]);
        checks++;
        if (Busy !== 1'b0 || TX_pin !== 1'b1) begin
          errors++;
          $display("FAIL end idle: busy=%b tx=%b want 0/1", Busy, TX_pin);
        end
      end
      begin
        if (mid_at > 0) begin
          repeat (mid_at) @(negedge CLK);
          Divisor = mid_div;
        end
      end
    join
    @(negedge CLK);
    checks++;
    if (done_cnt - d0 != exp_q.size()) begin
      errors++;
      $display("FAIL done count: got %0d want %0d", done_cnt - d0, exp_q.size());
    end
    checks++;
    if (ovf_cnt - o0 != exp_ovf) begin
      errors++;
      $display("FAIL overflow count: got %0d want %0d", ovf_cnt - o0, exp_ovf);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_pin !== 1'b1) begin errors++; $display("FAIL reset tx: got %b want 1", TX_pin); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", Busy); end
    checks++;
    if (Doneflg !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", Doneflg); end
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", Overflow); end
    checks++;
    if (Full !== 1'b0) begin errors++; $display("FAIL reset full: got %b want 0", Full); end
    checks++;
    if (Level !== 3'd0) begin errors++; $display("FAIL reset level: got %0d want 0", Level); end
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_pin !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL post-reset idle: tx=%b busy=%b want 1/0", TX_pin, Busy);
    end
  endtask

  task automatic test_basic_8n1();
    clear_plan();
    Divisor = 20'd4; FrameCheck = 2'b00; StopBits = 1'b0;
    add_frame(8'h55, 4, 2'b00, 1'b0);
    run_frames();
  endtask

  task automatic test_parity();
    clear_plan();
    Divisor = 20'd3; FrameCheck = 2'b10; StopBits = 1'b1;
    add_frame(8'h07, 3, 2'b10, 1'b1);
    add_frame(8'h07, 3, 2'b10, 1'b1);
    run_frames();
    clear_plan();
    FrameCheck = 2'b01;
    add_frame(8'h07, 3, 2'b01, 1'b1);
    run_frames();
  endtask

  task automatic test_back_to_back();
    logic [1:0] pm;
    clear_plan();
    pm = 2'($urandom_range(0, 3));
    Divisor = 20'd3; FrameCheck = pm; StopBits = 1'b0;
    add_frame(8'hA1, 3, pm, 1'b0);
    add_frame(8'hB2, 3, pm, 1'b0);
    add_frame(8'hC3, 3, pm, 1'b0);
    run_frames();
  endtask

  task automatic test_overflow();
    int nwr;
    clear_plan();
    nwr = 6;
    Divisor = 20'd1000; FrameCheck = 2'b00; StopBits = 1'b0;
    add_frame(8'($urandom), 1000, 2'b00, 1'b0);
    pre_gap = 2;
    mid_at = 3;
    mid_div = 20'd2;
    for (int k = 0; k < nwr; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      wr_q.push_back(d);
      if (k < DEPTH) begin
        frame_t f;
        f.d = d; f.div = 2; f.pm = 2'b00; f.s2 = 1'b0;
        exp_q.push_back(f);
      end
    end
    chk_sat = 1;
    exp_level = (nwr < DEPTH) ? nwr : DEPTH;
    exp_ovf = nwr - exp_level;
    run_frames();
    repeat (20) @(negedge CLK);
    checks++;
    if (TX_pin !== 1'b1 || Busy !== 1'b0 || Level !== 3'd0) begin
      errors++;
      $display("FAIL dropped sent: tx=%b busy=%b level=%0d want 1/0/0", TX_pin, Busy, Level);
    end
  endtask

  task automatic test_clamp_latch();
    clear_plan();
    Divisor = 20'd0; FrameCheck = 2'b00; StopBits = 1'b0;
    add_frame(8'($urandom), 0, 2'b00, 1'b0);
    run_frames();
    clear_plan();
    Divisor = 20'd4;
    add_frame(8'($urandom), 4, 2'b00, 1'b0);
    add_frame(8'($urandom), 8, 2'b00, 1'b0);
    mid_at = 6;
    mid_div = 20'd8;
    run_frames();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n, div;
      logic [1:0] pm;
      logic s2;
      clear_plan();
      n = $urandom_range(1, DEPTH);
      div = $urandom_range(0, 6);
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      Divisor = 20'(div); FrameCheck = pm; StopBits = s2;
      for (int k = 0; k < n; k++) add_frame(8'($urandom), div, pm, s2);
      run_frames();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    bit bad;
    d = 8'($urandom);
    Divisor = 20'd4; FrameCheck = 2'b00; StopBits = 1'b0;
    write_byte(d);
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    repeat (16) @(negedge CLK);
    checks++;
    if (TX_pin !== d[3] || Busy !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset bit3: tx=%b busy=%b want %b/1", TX_pin, Busy, d[3]);
    end
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (TX_pin !== 1'b1) begin errors++; $display("FAIL async reset tx: got %b want 1", TX_pin); end
    checks++;
    if (Level !== 3'd0 || Busy !== 1'b0 || Full !== 1'b0) begin
      errors++;
      $display("FAIL async reset state: level=%0d busy=%b full=%b want 0/0/0", Level, Busy, Full);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (TX_pin !== 1'b1 || Busy !== 1'b0 || Level !== 3'd0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL after reset idle: tx=%b busy=%b level=%0d want 1/0/0", TX_pin, Busy, Level);
    end
    clear_plan();
    add_frame(8'($urandom), 4, 2'b00, 1'b0);
    run_frames();
  endtask

  initial begin
    clear_plan();
    @(negedge CLK);
    test_reset();
    test_basic_8n1();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_clamp_latch();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered, parametrised UART transmitter: a synchronous TX FIFO feeding a frame serialiser with runtime-selectable baud divisor, parity mode and stop-bit count. It replaces the single-byte UART transmit path in the FCU UART subsystem. Host logic can queue up to FIFO_DEPTH characters, and they are sent back-to-back with no idle gap.

## Interface
- DATA_W, default 8: character width in bits, legal range 5..9.
- FIFO_DEPTH, default 16: TX FIFO entries, power of two, at least 2.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- CLK, input, 1: system clock.
- RSTn, input, 1: asynchronous active-low reset.
- WrEn, input, 1: write strobe; pushes WrData when accepted.
- WrData, input, DATA_W: character to queue.
- Divisor, input, 20: CLK cycles per bit. Values below 2 are treated as 2.
- FrameCheck, input, 2: parity mode. 00 = none, 01 = odd, 10 = even, 11 = none.
- StopBits, input, 1: 0 = one stop bit, 1 = two stop bits.
- TX_pin, output, 1: serial line, idle high, registered.
- Full, output, 1: FIFO holds FIFO_DEPTH entries.
- Level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- Busy, output, 1: serialiser is not IDLE.
- Doneflg, output, 1: one-cycle pulse when a frame's final stop bit completes.
- Overflow, output, 1: one-cycle pulse when a write is dropped.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE → START when the FIFO is non-empty. On that transition:
  - pop the head entry into the shift register;
  - latch Divisor, FrameCheck and StopBits;
  - drive TX_pin = 0.
- Config inputs changed mid-frame take effect on the next frame only.
- START → DATA after one bit time.
- DATA sends DATA_W bits, LSB first.
- After the last data bit:
  - go to PARITY if the latched mode is 01 or 10;
  - otherwise go to STOP.
- Parity bit value:
  - even: XOR of the data bits;
  - odd: inverted XOR of the data bits.
- STOP drives 1 for one or two bit times.
- At the end of STOP:
  - pulse Doneflg;
  - if the FIFO is non-empty, pop and enter START on the same edge (no idle gap);
  - otherwise return to IDLE.
- Baud counter: 20-bit, reloads at each bit boundary. Each bit lasts exactly max(Divisor, 2) cycles.
- FIFO write rules:
  - a write is accepted when not Full, or when Full and a pop occurs on the same edge;
  - otherwise the write is dropped and Overflow pulses;
  - Level updates by +1, −1 or 0 accordingly.
- Reset values:
  - TX_pin = 1;
  - Busy, Doneflg, Overflow and Full = 0;
  - Level = 0;
  - FSM in IDLE, FIFO pointers at 0.
- Reset asserted mid-frame drives TX_pin high immediately (asynchronously) and discards all queued data.

## Timing
- A write accepted at edge E0 into an empty FIFO, with the FSM in IDLE, appears as TX_pin low after edge E1. Latency is one cycle.
- Frame length in bit times is 1 + DATA_W + P + S:
  - P = 1 if parity is enabled, else 0;
  - S = 1 or 2 stop bits.
- Doneflg is asserted in the cycle after the final stop-bit cycle, i.e. coincident with the next START when queued.
- Busy is high from edge E1 through the end of the final STOP. It stays high across back-to-back frames.
- Full and Level are registered and reflect the state after the edge.

## Structure
- Shared package uart_pkg holds:
  - FSM state enum;
  - parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN);
  - the minimum divisor constant (2).
- Sub-module uart_sync_fifo: a single-clock FIFO parametrised by width and depth. It provides Full, Empty and Level, and supports push and pop on the same edge.
- Serialiser FSM, baud counter and bit counter live in the top module.

## Test plan
- Basic 8N1 frame: DATA_W=8, Divisor=4, FrameCheck=00, StopBits=0; write 0x55.
  - TX_pin sequence: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - Doneflg pulses 40 cycles after TX_pin first falls.
- Parity: write 0x07 with Divisor=3.
  - FrameCheck=10 (even): parity bit = 1.
  - FrameCheck=01 (odd): parity bit = 0.
  - StopBits=1: the line stays high for 6 cycles before the next start bit.
- Back-to-back: write 0xA1, 0xB2, 0xC3 on consecutive cycles.
  - Three contiguous frames with no idle cycles between them.
  - Doneflg pulses exactly 3 times; Busy stays high throughout.
- Overflow: FIFO_DEPTH=4 with the serialiser stalled in a long frame (Divisor=1000); write 6 entries.
  - Level saturates at 4; Full = 1; Overflow pulses twice.
  - Entries 5 and 6 are never transmitted.
- Divisor clamp and config latch:
  - Divisor=0 yields 2-cycle bits.
  - Changing Divisor from 4 to 8 mid-frame takes effect on the next frame only.
- Reset mid-frame: assert RSTn=0 during the DATA bit 3 of a frame.
  - TX_pin is 1 immediately; Level, Busy and Full are 0.
  - After release, the line stays idle until a new write.
